// File: rtl/i2c_eeprom_sched.sv
// i2c_eeprom_sched: shares one byte-level I2C master between two single-byte EEPROM requesters
// Ports: sys_clk/clr clock and sync reset; req/req_rw/req_addr/req_wdata per-requester requests;
//        done/rdata/err completion; busy; m_go/m_cmd/m_txd/m_abort command side and
//        m_done/m_nack/m_rxd completion side of the I2C master.
module i2c_eeprom_sched #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int MAX_RETRY = 8,
  parameter int POLL_GAP = 1250,
  parameter int TIMEOUT = 100000
) (
  input  logic        sys_clk,
  input  logic        clr,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rw,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic        m_go,
  output logic [2:0]  m_cmd,
  output logic [7:0]  m_txd,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic [7:0]  m_rxd,
  output logic        m_abort
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(POLL_GAP - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [3:0] {IDLE, START, WA0, WAH, WAL, WDAT, RSTART, WA1, READ, STOP, GAP, DONE} state_t;
  state_t state, nxt;
  logic sent, gnt, ptr, pick, rw, err_r, rpend, cmd_st, wr_st, ack, timeout;
  logic [15:0] addr;
  logic [7:0] wdata, rx;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  assign cmd_st = !(state inside {IDLE, GAP, DONE});
  assign wr_st = state inside {WA0, WAH, WAL, WDAT, WA1};
  // sent marks that this state's command is outstanding, so an m_done on the go cycle is ignored
  assign ack = sent && m_done;
  assign timeout = sent && !m_done && timer == TO_LAST;
  assign pick = req[ptr] ? ptr : ~ptr;
  assign m_go = cmd_st && !sent;
  assign m_abort = timeout;
  assign busy = state != IDLE;
  assign done = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign err = (state == DONE) && err_r;
  assign m_cmd = (state == START || state == RSTART) ? 3'd1 : wr_st ? 3'd2 :
                 (state == READ) ? 3'd3 : (state == STOP) ? 3'd4 : 3'd0;
  assign m_txd = (state == WA0) ? {DEV_ADDR, 1'b0} : (state == WAH) ? addr[15:8] :
                 (state == WAL) ? addr[7:0] : (state == WDAT) ? wdata :
                 (state == WA1) ? {DEV_ADDR, 1'b1} : 8'h00;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? START : IDLE;
      START:   nxt = ack ? WA0 : START;
      WA0:     nxt = ack ? (m_nack ? STOP : WAH) : WA0;
      WAH:     nxt = ack ? (m_nack ? STOP : WAL) : WAH;
      WAL:     nxt = ack ? (m_nack ? STOP : (rw ? RSTART : WDAT)) : WAL;
      WDAT:    nxt = ack ? STOP : WDAT;
      RSTART:  nxt = ack ? WA1 : RSTART;
      WA1:     nxt = ack ? (m_nack ? STOP : READ) : WA1;
      READ:    nxt = ack ? STOP : READ;
      STOP:    nxt = ack ? (rpend ? GAP : DONE) : STOP;
      GAP:     nxt = (timer == GAP_LAST) ? START : GAP;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (timeout) nxt = DONE;
  end
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state <= IDLE;
      sent <= 1'b0;
      gnt <= 1'b0;
      ptr <= 1'b0;
      rw <= 1'b0;
      err_r <= 1'b0;
      rpend <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rx <= '0;
      rdata <= '0;
      retry <= '0;
      timer <= '0;
    end else begin
      state <= nxt;
      sent <= (nxt == state) && (sent || m_go);
      // one counter serves both the per-command timeout and the poll gap
      timer <= (nxt != state || m_go) ? '0 : timer + TW'(1);
      if (state == IDLE && |req) begin
        gnt <= pick;
        ptr <= ~pick;
        rw <= req_rw[pick];
        addr <= pick ? req_addr[31:16] : req_addr[15:0];
        wdata <= pick ? req_wdata[15:8] : req_wdata[7:0];
        err_r <= 1'b0;
        rpend <= 1'b0;
        rx <= '0;
      end
      if (wr_st && ack && m_nack) begin
        if (state == WA0 && retry != RETRY_MAX) begin
          rpend <= 1'b1;
          retry <= retry + RW'(1);
        end else err_r <= 1'b1;
      end
      if (state == GAP) rpend <= 1'b0;
      if (state == READ && ack) rx <= m_rxd;
      if (timeout) err_r <= 1'b1;
      if (nxt == DONE && state != DONE) rdata <= rw ? rx : 8'h00;
      if (state == DONE) retry <= '0;
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_sched.sv
// tb_i2c_eeprom_sched: randomized scenario bench with an I2C master responder and a transaction-level model
module tb_i2c_eeprom_sched;
  localparam int MAXR = 8;
  localparam int GAPC = 1250;
  localparam int TO = 5000;
  typedef logic [10:0] ent_t;
  localparam ent_t ST = {3'd1, 8'h00};
  localparam ent_t RD = {3'd3, 8'h00};
  localparam ent_t SP = {3'd4, 8'h00};
  logic sys_clk = 1'b0, clr = 1'b1;
  logic [1:0] req = '0, req_rw = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] done;
  logic [7:0] rdata, m_txd, m_rxd;
  logic err, busy, m_go, m_abort, m_done, m_nack;
  logic [2:0] m_cmd;
  int checks = 0, errors = 0, cyc = 0;
  ent_t trace[$], exp_q[$];
  bit exp_err, out_s, hold_done = 1'b0, cur_dev;
  int exp_abort, cnt, a0_left, nack_pos, wpos, last_stop, min_gap, aborts;
  logic [2:0] cur_cmd, last_cmd;
  logic [7:0] cur_txd, rx_val;

  i2c_eeprom_sched #(.DEV_ADDR(7'h50), .MAX_RETRY(MAXR), .POLL_GAP(GAPC), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .clr(clr), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .m_go(m_go), .m_cmd(m_cmd), .m_txd(m_txd), .m_done(m_done), .m_nack(m_nack),
    .m_rxd(m_rxd), .m_abort(m_abort));

  initial forever #5 sys_clk = ~sys_clk;

  // I2C master stand-in: completes each command after 1..4 cycles, NACKs per the scenario knobs
  initial begin
    m_done = 1'b0; m_nack = 1'b0; m_rxd = '0; out_s = 1'b0; last_cmd = '0;
    forever begin
      @(posedge sys_clk); #1;
      cyc++;
      m_done = 1'b0; m_nack = 1'b0; m_rxd = '0;
      if (clr || m_abort) begin
        out_s = 1'b0;
        last_cmd = '0;
      end else if (out_s) begin
        if (cur_cmd == 3'd2) begin
          checks++;
          if (m_txd !== cur_txd) begin errors++; $display("FAIL txd_stable: m_txd %h required %h", m_txd, cur_txd); end
        end
        if (!hold_done) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            m_done = 1'b1; out_s = 1'b0;
            if (cur_cmd == 3'd2) begin
              if (cur_dev) begin
                wpos = 0;
                if (a0_left > 0) begin m_nack = 1'b1; a0_left = a0_left - 1; end
              end else begin
                wpos = wpos + 1;
                if (wpos == nack_pos) m_nack = 1'b1;
              end
            end
            if (cur_cmd == 3'd3) m_rxd = rx_val;
            if (cur_cmd == 3'd4) last_stop = cyc;
          end
        end
      end
      if (m_go) begin
        checks++;
        if (out_s) begin errors++; $display("FAIL m_go_exclusive: m_go %b while command %0d outstanding", m_go, cur_cmd); end
        cur_dev = (last_cmd == 3'd1) && m_cmd == 3'd2 && m_txd == 8'hA0;
        if (m_cmd == 3'd1 && last_stop >= 0 && cyc - last_stop < min_gap) min_gap = cyc - last_stop;
        trace.push_back({m_cmd, (m_cmd == 3'd2) ? m_txd : 8'h00});
        cur_cmd = m_cmd; cur_txd = m_txd; last_cmd = m_cmd; out_s = 1'b1;
        cnt = $urandom_range(1, 4);
      end
    end
  end

  task automatic tick;
    @(posedge sys_clk); #2;
  endtask

  function automatic ent_t W(input logic [7:0] b);
    return {3'd2, b};
  endfunction

  // expected command trace of one transaction, built straight from the sequence rules
  task automatic model(input bit rw, input logic [15:0] a, input logic [7:0] wd, input int a0n, input int npos);
    exp_q = {}; exp_err = 1'b0; exp_abort = 0;
    for (int t = 0; t <= MAXR; t++) begin
      exp_q.push_back(ST); exp_q.push_back(W(8'hA0));
      if (t >= a0n) break;
      exp_q.push_back(SP);
      if (t == MAXR) begin exp_err = 1'b1; return; end
    end
    exp_q.push_back(W(a[15:8]));
    if (npos == 1) begin exp_q.push_back(SP); exp_err = 1'b1; return; end
    exp_q.push_back(W(a[7:0]));
    if (npos == 2) begin exp_q.push_back(SP); exp_err = 1'b1; return; end
    if (!rw) begin
      exp_q.push_back(W(wd));
      if (npos == 3) exp_err = 1'b1;
      exp_q.push_back(SP);
      return;
    end
    exp_q.push_back(ST); exp_q.push_back(W(8'hA1));
    if (npos == 3) begin exp_q.push_back(SP); exp_err = 1'b1; return; end
    exp_q.push_back(RD); exp_q.push_back(SP);
  endtask

  task automatic run_txn(input int i, input bit rw, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rxv, input int a0n, input int npos, input string nm);
    logic [7:0] exp_rd;
    bit ok;
    trace = {}; rx_val = rxv; a0_left = a0n; nack_pos = npos; wpos = 0;
    last_stop = -1; min_gap = 1 << 30; aborts = 0;
    req_rw[i] = rw; req_addr[16*i +: 16] = a; req_wdata[8*i +: 8] = wd; req[i] = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: busy %b required 1", nm, busy); end
    req = '0; req_addr = 32'($urandom); req_wdata = 16'($urandom); req_rw = 2'($urandom);
    for (int n = 0; n < 30000 && done === 2'b00; n++) begin
      if (m_abort) aborts++;
      tick;
    end
    exp_rd = (rw && !exp_err) ? rxv : 8'h00;
    checks++;
    if (done !== 2'(1 << i)) begin errors++; $display("FAIL %s done: done %b required %b", nm, done, 2'(1 << i)); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s err: err %b required %b", nm, err, exp_err); end
    checks++;
    if (rdata !== exp_rd) begin errors++; $display("FAIL %s rdata: rdata %h required %h", nm, rdata, exp_rd); end
    checks++;
    if (aborts != exp_abort) begin errors++; $display("FAIL %s abort: %0d m_abort pulses required %0d", nm, aborts, exp_abort); end
    tick;
    checks++;
    if ({done, busy} !== 3'b000) begin errors++; $display("FAIL %s busy_fall: done %b busy %b required 00 0", nm, done, busy); end
    ok = trace.size() == exp_q.size();
    if (ok) foreach (exp_q[k]) if (trace[k] !== exp_q[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s trace: %0d commands, first %h, required %0d commands, first %h", nm, trace.size(),
               (trace.size() > 0) ? trace[0] : 11'h0, exp_q.size(), exp_q[0]);
    end
    if (a0n > 0) begin
      checks++;
      if (min_gap < GAPC) begin errors++; $display("FAIL %s poll_gap: %0d cycles required >= %0d", nm, min_gap, GAPC); end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    tick; tick;
    checks++;
    if ({done, err, busy, m_go, m_abort, m_cmd, m_txd, rdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset: done %b err %b busy %b go %b abort %b cmd %0d txd %h rdata %h required all 0",
               done, err, busy, m_go, m_abort, m_cmd, m_txd, rdata);
    end
    clr = 1'b0;
    tick;
  endtask

  task automatic test_write;
    model(1'b0, 16'h0A55, 8'h43, 0, 0);
    run_txn(0, 1'b0, 16'h0A55, 8'h43, 8'h00, 0, 0, "write");
  endtask

  task automatic test_read_poll;
    model(1'b1, 16'h0A55, 8'h00, 2, 0);
    run_txn(0, 1'b1, 16'h0A55, 8'h00, 8'h43, 2, 0, "read_poll");
  endtask

  task automatic test_clr_mid;
    bit found = 1'b0;
    int dn = 0;
    trace = {}; a0_left = 0; nack_pos = 0; wpos = 0; last_stop = -1;
    req_rw[0] = 1'b0; req_addr[15:0] = 16'h0A55; req_wdata[7:0] = 8'h43; req[0] = 1'b1;
    tick;
    req = '0;
    for (int n = 0; n < 500; n++) begin
      if (trace.size() >= 4 && trace[3] === W(8'h55)) begin found = 1'b1; break; end
      tick;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL clr_mid reach: W 55 seen %b required 1", found); end
    clr = 1'b1;
    tick;
    checks++;
    if ({done, err, busy, m_go, m_abort, m_cmd, m_txd, rdata} !== 25'd0) begin
      errors++;
      $display("FAIL clr_mid outputs: done %b err %b busy %b go %b abort %b cmd %0d txd %h rdata %h required all 0",
               done, err, busy, m_go, m_abort, m_cmd, m_txd, rdata);
    end
    clr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (done !== 2'b00 || m_go !== 1'b0) dn++;
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL clr_mid quiet: %0d cycles with done/m_go required 0", dn); end
    model(1'b0, 16'h0A55, 8'h43, 0, 0);
    run_txn(0, 1'b0, 16'h0A55, 8'h43, 8'h00, 0, 0, "clr_mid_fresh");
  endtask

  task automatic test_round_robin;
    logic [1:0] want;
    clr = 1'b1; tick; clr = 1'b0; tick;
    a0_left = 0; nack_pos = 0; wpos = 0; last_stop = -1;
    req_rw = 2'b00; req_addr = 32'h1234_0A55; req_wdata = 16'h9943; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2000 && done === 2'b00; n++) tick;
      want = (k % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (done !== want) begin errors++; $display("FAIL rr_order %0d: done %b required %b", k, done, want); end
      if (k == 3) req = '0;
      tick;
    end
    repeat (5) tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: busy %b required 0", busy); end
  endtask

  task automatic test_retry_exhaust;
    model(1'b0, 16'h7F01, 8'h5A, 1000, 0);
    run_txn(1, 1'b0, 16'h7F01, 8'h5A, 8'h00, 1000, 0, "retry_exhaust");
  endtask

  task automatic test_nack_addr_lo;
    model(1'b0, 16'h0A55, 8'h43, 0, 2);
    run_txn(0, 1'b0, 16'h0A55, 8'h43, 8'h00, 0, 2, "nack_addr_lo");
  endtask

  task automatic test_timeout;
    exp_q = {ST}; exp_err = 1'b1; exp_abort = 1;
    hold_done = 1'b1;
    run_txn(1, 1'b1, 16'h0100, 8'h00, 8'hEE, 0, 0, "timeout");
    hold_done = 1'b0;
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int i = $urandom_range(0, 1);
      bit rw = 1'($urandom);
      logic [15:0] a = 16'($urandom);
      logic [7:0] wd = 8'($urandom), rxv = 8'($urandom);
      int a0n = $urandom_range(0, 1);
      int npos = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      model(rw, a, wd, a0n, npos);
      run_txn(i, rw, a, wd, rxv, a0n, npos, "random");
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_poll;
    test_clr_mid;
    test_round_robin;
    test_retry_exhaust;
    test_nack_addr_lo;
    test_timeout;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_eeprom_sched.md
Name: i2c_eeprom_sched

Overview:
- Transaction scheduler that shares one byte-level I2C master between two requesters, e.g. the display fetch path and a configuration writer.
- Each requester posts a single-byte EEPROM read or write at a 16-bit address.
- The block arbitrates round-robin and expands the request into the START / byte / STOP command sequence.
- It performs ACK polling while the EEPROM is busy with an internal write cycle, and returns read data plus an error flag.

Parameters:
- DEV_ADDR, 7'h50, 7-bit EEPROM device address (write byte 0xA0, read byte 0xA1).
- MAX_RETRY, 8, maximum re-attempts after a device-address NACK.
- POLL_GAP, 1250, idle cycles between a NACK-STOP and the retry START (25 us at 50 MHz).
- TIMEOUT, 100000, maximum cycles to wait for m_done on any command.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- clr  in  1  synchronous reset, active-high.
- req  in  2  per-requester request level; bit i = requester i.
- req_rw  in  2  per requester: 1 = read, 0 = write.
- req_addr  in  32  {addr1[15:0], addr0[15:0]}.
- req_wdata  in  16  {wdata1, wdata0}.
- done  out  2  one-cycle completion pulse, per requester.
- rdata  out  8  read byte; valid on the done pulse.
- err  out  1  error flag; valid on the done pulse.
- busy  out  1  high while a transaction is in progress.
- m_go  out  1  one-cycle command strobe to the I2C master.
- m_cmd  out  3  command code: 1 = START (repeated if the bus is held), 2 = WRITE byte, 3 = READ byte with master NACK, 4 = STOP.
- m_txd  out  8  byte for WRITE; held stable from m_go until m_done.
- m_done  in  1  one-cycle pulse when the master finishes a command.
- m_nack  in  1  ACK-slot SDA sampled on a WRITE; valid with m_done; 1 = NACK.
- m_rxd  in  8  byte received on READ; valid with m_done.
- m_abort  out  1  one-cycle pulse on timeout; the master returns to idle.

Behaviour:
- Reset (clr high at a sys_clk edge):
  - State goes to IDLE.
  - done, err, busy, m_go and m_abort go to 0; m_cmd, m_txd and rdata go to 0.
  - Round-robin pointer favours requester 0.
  - Reset mid-transaction abandons the transaction with no STOP issued and no done pulse.
- Arbitration (IDLE):
  - Any req bit high grants one requester; the pointer requester wins if both are high.
  - The pointer is set to the other requester after each grant.
  - Requester index, rw, addr and wdata are latched on the grant cycle; later input changes are ignored.
  - busy rises the cycle after the grant.
- Command issue:
  - Each command state pulses m_go exactly once on its first cycle.
  - The state then waits for m_done.
  - An m_done arriving in the same cycle as m_go is ignored.
- Write sequence: START, WRITE A0, WRITE addr[15:8], WRITE addr[7:0], WRITE wdata, STOP, DONE.
- Read sequence: START, WRITE A0, WRITE addr[15:8], WRITE addr[7:0], START, WRITE A1, READ, STOP, DONE. rdata is latched from m_rxd on the READ m_done.
- NACK on the A0 byte:
  - Issue STOP, then wait POLL_GAP cycles in GAP, then restart from the first START.
  - The retry counter increments per NACK.
  - If the counter exceeds MAX_RETRY: STOP, then DONE with err = 1.
- NACK on any other written byte (addr_hi, addr_lo, wdata, A1): STOP, then DONE with err = 1; no retry.
- Timeout:
  - A per-command counter resets on every m_go.
  - Reaching TIMEOUT pulses m_abort, skips the STOP and enters DONE with err = 1.
- DONE:
  - Pulse done[granted] for one cycle, drive err, and hold rdata (0 for writes) until the next done.
  - Clear the retry counter; busy falls and the state returns to IDLE on the next cycle.
- A new grant is possible on the cycle after DONE.
- A requester must drop req the cycle after its done pulse; req still high then is treated as a new request.
- Ownership of the master is exclusive: m_go is never asserted while a command is outstanding.

Test Plan:
- Requester 0 writes 0x0A55 = 0x43, all ACKs:
  - Command/byte trace is START, W A0, W 0A, W 55, W 43, STOP.
  - done = 2'b01 once, err = 0, busy falls 1 cycle after done.
- Requester 0 reads 0x0A55; master NACKs A0 twice then ACKs, m_rxd = 0x43:
  - Exactly 3 leading STARTs, each separated from the preceding STOP by at least 1250 cycles.
  - Trace then continues W 0A, W 55, START, W A1, READ, STOP.
  - rdata = 0x43, err = 0.
- req = 2'b11 held and re-asserted after each done, after reset: grant order 0, 1, 0, 1; no m_go while busy with the other requester.
- A0 always NACKed: 9 attempts (MAX_RETRY + 1), each ending in STOP, then done with err = 1.
- NACK on the address-low byte of a write: STOP immediately, err = 1, no retry. Separately, withholding m_done for 100000 cycles gives an m_abort pulse and err = 1.
- clr asserted during the W 55 command: all outputs return to reset values next cycle; the next request starts from a fresh START.
